// File: rtl/hazard_ctrl_unit_if.sv
// Hazard control bundle between the ID stage and the hazard control unit.
// The pipeline side (master) supplies operand/destination information and
// consumes the stall, bubble, freeze and flush controls; the hazard unit
// (slave) does the reverse.
interface hazard_ctrl_unit_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned PERF_W = 32
);
   logic [ADDR_W-1:0] RS1addr_i;
   logic [ADDR_W-1:0] RS2addr_i;
   logic              RS1use_i;
   logic              RS2use_i;
   logic              MemRead_i;
   logic [ADDR_W-1:0] RDaddr_i;
   logic              mem_stall_i;
   logic              flush_i;
   logic              stall_o;
   logic              PCWrite_o;
   logic              NoOp_o;
   logic              Freeze_o;
   logic              Flush_o;
   logic [PERF_W-1:0] lu_cnt_o;

   modport master (
      output RS1addr_i, RS2addr_i, RS1use_i, RS2use_i,
      output MemRead_i, RDaddr_i, mem_stall_i, flush_i,
      input  stall_o, PCWrite_o, NoOp_o, Freeze_o, Flush_o, lu_cnt_o
   );

   modport slave (
      input  RS1addr_i, RS2addr_i, RS1use_i, RS2use_i,
      input  MemRead_i, RDaddr_i, mem_stall_i, flush_i,
      output stall_o, PCWrite_o, NoOp_o, Freeze_o, Flush_o, lu_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// ID-stage load-use hazard controller. Inserts LOAD_LAT bubbles per
// load-use hazard, yields to data-cache freezes, suppresses branch flushes
// while the branch operands are stale, and counts load-use bubbles.
module hazard_ctrl_unit #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned X0_EXEMPT = 1,
   parameter int unsigned PERF_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   hazard_ctrl_unit_if.slave hz
);

   typedef enum logic {IDLE, LU_WAIT} state_t;

   // Out-of-range latencies are clamped so the 4-bit bubble counter stays valid.
   localparam int unsigned LAT_C  = (LOAD_LAT < 1) ? 1 : ((LOAD_LAT > 15) ? 15 : LOAD_LAT);
   localparam logic [3:0]  LAT_M1 = 4'(LAT_C - 1);
   localparam logic        MULTI  = (LAT_C > 1);
   localparam logic        X0_EX  = (X0_EXEMPT != 0);

   state_t            state;
   logic [3:0]        cnt;
   logic [PERF_W-1:0] lu_cnt;

   logic rs1_match;
   logic rs2_match;
   logic rd_is_x0;
   logic hit;
   logic lu;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      if (&v)
         return v;
      return v + PERF_W'(1);
   endfunction

   // Hazard detection and load-use condition, purely combinational.
   always_comb begin
      rs1_match = hz.RS1use_i && (hz.RDaddr_i == hz.RS1addr_i);
      rs2_match = hz.RS2use_i && (hz.RDaddr_i == hz.RS2addr_i);
      rd_is_x0  = X0_EX && (hz.RDaddr_i == ADDR_W'(0));
      hit       = hz.MemRead_i && (rs1_match || rs2_match) && !rd_is_x0;
      lu        = ((state == IDLE) && hit) || (state == LU_WAIT);
   end

   // Bubble FSM and stall counter; everything holds while the cache freezes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         lu_cnt <= '0;
      end else if (!hz.mem_stall_i) begin
         if (lu)
            lu_cnt <= sat_inc(lu_cnt);
         case (state)
            IDLE: begin
               // A single-bubble hazard clears itself: the bubble reaches
               // ID/EX next cycle and the hit disappears.
               if (hit && MULTI) begin
                  state <= LU_WAIT;
                  cnt   <= LAT_M1;
               end
            end
            LU_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Pipeline control outputs: freeze beats load-use, load-use beats flush.
   always_comb begin
      hz.stall_o   = 1'b0;
      hz.PCWrite_o = 1'b1;
      hz.NoOp_o    = 1'b0;
      hz.Freeze_o  = 1'b0;
      hz.Flush_o   = 1'b0;
      if (hz.mem_stall_i) begin
         hz.Freeze_o  = 1'b1;
         hz.stall_o   = 1'b1;
         hz.PCWrite_o = 1'b0;
      end else if (lu) begin
         // Branch operands are stale during the stall; the branch
         // re-resolves once the load data is available.
         hz.stall_o   = 1'b1;
         hz.PCWrite_o = 1'b0;
         hz.NoOp_o    = 1'b1;
      end else begin
         hz.Flush_o = hz.flush_i;
      end
   end

   assign hz.lu_cnt_o = lu_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: five configurations share one
// stimulus stream; per-cycle expectations go into a scoreboard queue and are
// compared on the falling clock edge.
module tb_hazard_ctrl_unit;

   localparam int NI = 5;
   // Control vector order: {stall, PCWrite, NoOp, Freeze, Flush}
   localparam logic [4:0] IDL = 5'b01000;
   localparam logic [4:0] FLS = 5'b01001;
   localparam logic [4:0] BUB = 5'b10100;
   localparam logic [4:0] FRZ = 5'b10010;

   // inst0: LAT1, inst1: LAT1 no x0 exemption, inst2: LAT3, inst3: LAT4,
   // inst4: LAT1 with 4-bit counter
   function automatic int lat_of(input int i);
      case (i)
         2: return 3;
         3: return 4;
         default: return 1;
      endcase
   endfunction
   function automatic int x0_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction
   function automatic int pw_of(input int i);
      return (i == 4) ? 4 : 32;
   endfunction

   logic       clk;
   logic       rst;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, mr, ms, fl;

   logic [4:0]  ctl_obs [NI];
   logic [31:0] cnt_obs [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = lat_of(g);
      localparam int X0  = x0_of(g);
      localparam int PW  = pw_of(g);
      hazard_ctrl_unit_if #(.ADDR_W(5), .PERF_W(PW)) ifc ();
      assign ifc.RS1addr_i   = rs1;
      assign ifc.RS2addr_i   = rs2;
      assign ifc.RS1use_i    = u1;
      assign ifc.RS2use_i    = u2;
      assign ifc.MemRead_i   = mr;
      assign ifc.RDaddr_i    = rd;
      assign ifc.mem_stall_i = ms;
      assign ifc.flush_i     = fl;
      hazard_ctrl_unit #(
         .ADDR_W(5), .LOAD_LAT(LAT), .X0_EXEMPT(X0), .PERF_W(PW)
      ) dut (
         .clk_i(clk),
         .rst_i(rst),
         .hz   (ifc)
      );
      assign ctl_obs[g] = {ifc.stall_o, ifc.PCWrite_o, ifc.NoOp_o, ifc.Freeze_o, ifc.Flush_o};
      assign cnt_obs[g] = 32'(ifc.lu_cnt_o);
   end

   typedef struct {
      string       tag;
      int          inst;
      logic [4:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input string tag, input int inst, input logic [4:0] ctl, input int cnt);
      exp_t e;
      e.tag  = tag;
      e.inst = inst;
      e.ctl  = ctl;
      e.cnt  = 32'(cnt);
      sb.push_back(e);
   endtask

   task automatic drv(input logic m, input logic [4:0] d, input logic [4:0] a1, input logic e1,
                      input logic [4:0] a2, input logic e2, input logic s, input logic f);
      mr = m; rd = d; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; ms = s; fl = f;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // One clock cycle: check every queued expectation mid-cycle, then advance.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_assert++;
         assert (ctl_obs[e.inst] === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl inst%0d observed=%b expected=%b", e.tag, e.inst, ctl_obs[e.inst], e.ctl);
         end
         n_assert++;
         assert (cnt_obs[e.inst] === e.cnt) else begin
            n_fail++;
            $error("FAIL %s lu_cnt inst%0d observed=%0d expected=%0d", e.tag, e.inst, cnt_obs[e.inst], e.cnt);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      do_reset();

      // Reset state on every configuration
      for (int i = 0; i < NI; i++) push("reset", i, IDL, 0);
      cycle();

      // Single bubble with LOAD_LAT=1
      do_reset();
      drv(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      push("lat1_hit", 0, BUB, 0);
      cycle();
      idle();
      push("lat1_after", 0, IDL, 1);
      cycle();
      push("lat1_after2", 0, IDL, 1);
      cycle();

      // x0 exemption and operand-use gating
      do_reset();
      drv(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      push("x0_exempt", 0, IDL, 0);
      push("x0_noexempt", 1, BUB, 0);
      cycle();
      drv(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      push("rs2_unused", 0, IDL, 0);
      push("rs2_unused_nx", 1, IDL, 1);
      cycle();
      drv(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      push("rs2_used", 0, BUB, 0);
      cycle();
      idle();
      push("rs2_used_after", 0, IDL, 1);
      cycle();

      // Three bubbles with LOAD_LAT=3
      do_reset();
      drv(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      push("lat3_b1", 2, BUB, 0);
      cycle();
      idle();
      push("lat3_b2", 2, BUB, 1);
      cycle();
      push("lat3_b3", 2, BUB, 2);
      cycle();
      push("lat3_done", 2, IDL, 3);
      cycle();
      push("lat3_idle", 2, IDL, 3);
      cycle();

      // Freeze interleaved in the second bubble of a LOAD_LAT=3 sequence
      do_reset();
      drv(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      push("frz_b1", 2, BUB, 0);
      cycle();
      drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      push("frz_f1", 2, FRZ, 1);
      cycle();
      push("frz_f2", 2, FRZ, 1);
      cycle();
      idle();
      push("frz_b2", 2, BUB, 1);
      cycle();
      push("frz_b3", 2, BUB, 2);
      cycle();
      push("frz_done", 2, IDL, 3);
      cycle();

      // Freeze in the detection cycle: hit recurs once the freeze lifts
      do_reset();
      drv(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
      push("det_frz", 0, FRZ, 0);
      cycle();
      drv(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      push("det_bub", 0, BUB, 0);
      cycle();
      idle();
      push("det_done", 0, IDL, 1);
      cycle();

      // Branch flush against a hazard, then alone
      do_reset();
      drv(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      push("flush_hit", 0, BUB, 0);
      cycle();
      drv(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push("flush_alone", 0, FLS, 1);
      cycle();
      idle();
      push("flush_off", 0, IDL, 1);
      cycle();

      // Reset aborting a LOAD_LAT=4 sequence in its second cycle
      do_reset();
      drv(1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      push("abort_b1", 3, BUB, 0);
      cycle();
      idle();
      rst = 1'b1;
      push("abort_b2", 3, BUB, 1);
      cycle();
      rst = 1'b0;
      push("abort_after", 3, IDL, 0);
      cycle();
      push("abort_after2", 3, IDL, 0);
      cycle();

      // Counter saturation with a 4-bit counter
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drv(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
         push("sat_hit", 4, BUB, (i < 15) ? i : 15);
         cycle();
         idle();
         push("sat_idle", 4, IDL, (i + 1 < 15) ? i + 1 : 15);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
